// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared FSM state type and counter sizing helper.
// Parity feature macro: SERIAL_OUT_PARITY_EN.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Bits needed to hold the counter range 0..w-1.
  function automatic int CNT_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: parallel load handshake and serial status bundle.
// Parity feature macro: SERIAL_OUT_PARITY_EN.
interface piso_serializer_if #(
  parameter int WIDTH = 24
);

  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             D;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load,
    input  ready,
    input  D,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output D,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer_bitcnt.sv
// piso_bitcnt: loadable down-counter with zero flag for the bit index.
// Parity feature macro: SERIAL_OUT_PARITY_EN (not used here).
module piso_bitcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; reset clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with back-to-back loads.
// Define SERIAL_OUT_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int   CW      = CNT_W(WIDTH);
  localparam int   OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
  localparam logic IDLE_D  = (IDLE_LEVEL != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             r_d;
  logic             w_d_nxt;
  logic             r_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_final;
  logic             w_cnt_zero;
  logic             w_cnt_dec;

`ifdef SERIAL_OUT_PARITY_EN
  logic             r_par;
  logic             w_par_nxt;
`endif

  assign w_cnt_dec = (r_state == SHIFT) && !w_cnt_zero;

`ifdef SERIAL_OUT_PARITY_EN
  assign w_final = (r_state == PARITY);
`else
  assign w_final = (r_state == SHIFT) && w_cnt_zero;
`endif

  assign w_ready  = (r_state == IDLE) || w_final;
  assign w_accept = bus.load && w_ready;

  piso_bitcnt #(
    .W (CW)
  ) u_bitcnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_val  (CW'(WIDTH - 1)),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  // Next state, next shift contents and next serial bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_d_nxt     = IDLE_D;
`ifdef SERIAL_OUT_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      SHIFT: begin
        if (MSB_FIRST != 0) begin
          w_sr_nxt = {r_sr[WIDTH-2:0], 1'b0};
        end else begin
          w_sr_nxt = {1'b0, r_sr[WIDTH-1:1]};
        end
        if (w_cnt_zero) begin
`ifdef SERIAL_OUT_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_sr_nxt    = bus.din;
`ifdef SERIAL_OUT_PARITY_EN
      w_par_nxt   = ^bus.din;
`endif
    end
    if (w_state_nxt == SHIFT) begin
      w_d_nxt = w_sr_nxt[OUT_IDX];
`ifdef SERIAL_OUT_PARITY_EN
    end else if (w_state_nxt == PARITY) begin
      w_d_nxt = w_par_nxt;
`endif
    end
  end

  // State, data path and output registers; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_d     <= IDLE_D;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_d     <= w_d_nxt;
      r_done  <= w_final;
    end
  end

`ifdef SERIAL_OUT_PARITY_EN
  // Parity of the captured word, held for the trailing parity cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_nxt;
    end
  end
`endif

  assign bus.ready = w_ready;
  assign bus.D     = r_d;
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for two serializer configurations.
// Define SERIAL_OUT_PARITY_EN to expect the trailing parity bit.
module tb_piso_serializer;

  typedef struct packed {
    logic d;
    logic busy;
    logic ready;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(24)) ia ();
  piso_serializer_if #(.WIDTH(8))  ib ();

  piso_serializer #(
    .WIDTH      (24),
    .MSB_FIRST  (1),
    .IDLE_LEVEL (0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  piso_serializer #(
    .WIDTH      (8),
    .MSB_FIRST  (0),
    .IDLE_LEVEL (1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  exp_t qa[$];
  exp_t qb[$];
  logic pa = 1'b0;
  logic pb = 1'b0;
  int   tests = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string t, input logic d, input logic b,
                     input logic r, input logic dn, input exp_t e,
                     input logic pd);
    chk({t, ".D"}, d, e.d);
    chk({t, ".busy"}, b, e.busy);
    chk({t, ".ready"}, r, e.ready);
    chk({t, ".done"}, dn, pd);
  endtask

  function automatic exp_t idle_exp(input logic lvl);
    exp_t e;
    e.d = lvl;
    e.busy = 1'b0;
    e.ready = 1'b1;
    e.last = 1'b0;
    return e;
  endfunction

  task automatic push_frame(input int sel, input logic [63:0] w,
                            input int width, input bit msb);
    exp_t f[$];
    exp_t e;
    logic par;
    int idx;
    par = 1'b0;
    for (int i = 0; i < width; i++) begin
      idx = msb ? width - 1 - i : i;
      e.d = w[idx];
      e.busy = 1'b1;
      e.ready = 1'b0;
      e.last = 1'b0;
      par ^= w[idx];
      f.push_back(e);
    end
`ifdef SERIAL_OUT_PARITY_EN
    e.d = par;
    f.push_back(e);
`endif
    f[f.size()-1].ready = 1'b1;
    f[f.size()-1].last = 1'b1;
    foreach (f[i]) begin
      if (sel == 0) qa.push_back(f[i]);
      else qb.push_back(f[i]);
    end
  endtask

  task automatic step();
    exp_t ea;
    exp_t eb;
    @(posedge clk);
    #1;
    ea = (qa.size() > 0) ? qa.pop_front() : idle_exp(1'b0);
    eb = (qb.size() > 0) ? qb.pop_front() : idle_exp(1'b1);
    cmp("A", ia.D, ia.busy, ia.ready, ia.done, ea, pa);
    cmp("B", ib.D, ib.busy, ib.ready, ib.done, eb, pb);
    pa = ea.last;
    pb = eb.last;
  endtask

  task automatic check_now();
    cmp("A", ia.D, ia.busy, ia.ready, ia.done, idle_exp(1'b0), 1'b0);
    cmp("B", ib.D, ib.busy, ib.ready, ib.done, idle_exp(1'b1), 1'b0);
  endtask

  initial begin
    ia.load = 1'b0;
    ia.din = '0;
    ib.load = 1'b0;
    ib.din = '0;
    #1;
    rst = 1'b1;
    #1;
    check_now();
    step();
    step();
    rst = 1'b0;

    // A: 24'hA5C3F0 MSB-first; B: 8'h01 LSB-first with idle level 1.
    ia.load = 1'b1;
    ia.din = 24'hA5C3F0;
    push_frame(0, 64'hA5C3F0, 24, 1'b1);
    ib.load = 1'b1;
    ib.din = 8'h01;
    push_frame(1, 64'h01, 8, 1'b0);
    step();
    ia.load = 1'b0;
    ib.load = 1'b0;
    repeat (30) step();

    // B: back-to-back FF then 00 loaded in the final cycle.
    ib.load = 1'b1;
    ib.din = 8'hFF;
    push_frame(1, 64'hFF, 8, 1'b0);
    step();
    ib.load = 1'b0;
    while (qb.size() > 0) step();
    ib.load = 1'b1;
    ib.din = 8'h00;
    push_frame(1, 64'h00, 8, 1'b0);
    step();
    ib.load = 1'b0;
    repeat (12) step();

    // B: load held high with din toggling; only first word goes out.
    ib.load = 1'b1;
    ib.din = 8'h5A;
    push_frame(1, 64'h5A, 8, 1'b0);
    step();
    while (qb.size() > 0) begin
      ib.din = 8'($urandom);
      step();
    end
    ib.load = 1'b0;
    repeat (12) step();

    // A: reset in the middle of a frame, then a clean frame.
    ia.load = 1'b1;
    ia.din = 24'hC0FFEE;
    push_frame(0, 64'hC0FFEE, 24, 1'b1);
    step();
    ia.load = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    qa.delete();
    pa = 1'b0;
    check_now();
    step();
    step();
    rst = 1'b0;
    ia.load = 1'b1;
    ia.din = 24'h000001;
    push_frame(0, 64'h000001, 24, 1'b1);
    step();
    ia.load = 1'b0;
    repeat (30) step();

    // B: odd and even parity words back to back.
    ib.load = 1'b1;
    ib.din = 8'h07;
    push_frame(1, 64'h07, 8, 1'b0);
    step();
    ib.load = 1'b0;
    while (qb.size() > 0) step();
    ib.load = 1'b1;
    ib.din = 8'h03;
    push_frame(1, 64'h03, 8, 1'b0);
    step();
    ib.load = 1'b0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
